// File: rtl/startup_seq_pkg.sv
// Shared types for the startup sequencer: FSM state encoding.
package startup_seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WAIT_LOCK = 2'd0,
        ROC       = 2'd1,
        TOC       = 2'd2,
        RUN       = 2'd3
    } state_e;

endpackage

// File: rtl/startup_seq_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset; both flops reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/startup_seq.sv
// Startup sequencer: qualifies PLL lock, then releases GSR/PRLD and later GTS.
module startup_seq
    import startup_seq_pkg::*;
#(
    parameter int LOCK_FILTER = 16,
    parameter int ROC_CYCLES  = 100,
    parameter int TOC_CYCLES  = 0,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    input  logic relock_en,
    output logic gsr,
    output logic prld,
    output logic gts,
    output logic ready,
    output logic lock_lost
);

    localparam logic [CNT_W-1:0] LF_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] ROC_LAST = CNT_W'(ROC_CYCLES - 1);
    localparam logic [CNT_W-1:0] TOC_LAST = (TOC_CYCLES > 0) ? CNT_W'(TOC_CYCLES - 1) : '0;

    logic             locked_s;
    logic             locked_prev_q;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gsr_q, gsr_d;
    logic             gts_q, gts_d;
    logic             lock_lost_q, lock_lost_d;
    logic             lock_fall;

    sync_2ff u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= WAIT_LOCK;
            cnt_q         <= '0;
            locked_prev_q <= 1'b0;
            gsr_q         <= 1'b1;
            gts_q         <= 1'b1;
            lock_lost_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            locked_prev_q <= locked_s;
            gsr_q         <= gsr_d;
            gts_q         <= gts_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    // Lock loss is tested before terminal count so it always wins.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        unique case (state_q)
            WAIT_LOCK: begin
                if (!locked_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LF_LAST) begin
                    state_d = ROC;
                    cnt_d   = '0;
                end
            end
            ROC: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == ROC_LAST) begin
                    state_d = (TOC_CYCLES > 0) ? TOC : RUN;
                    cnt_d   = '0;
                end
            end
            TOC: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == TOC_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s && relock_en) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    assign lock_fall = locked_prev_q & ~locked_s;

    always_comb begin
        gsr_d       = (state_d == WAIT_LOCK) || (state_d == ROC);
        gts_d       = (state_d != RUN);
        lock_lost_d = (state_q != WAIT_LOCK) && lock_fall;
    end

    assign gsr       = gsr_q;
    assign prld      = gsr_q;
    assign gts       = gts_q;
    assign ready     = ~gts_q;
    assign lock_lost = lock_lost_q;

endmodule
